// File: rtl/inst_sram_responder_pkg.sv
// Shared definitions for the instruction-fetch SRAM responder and its wait-state counter.
package inst_sram_responder_pkg;

  localparam logic [31:0] INST_BASE_ADDR = 32'hBFB00000;
  localparam int          INST_W         = 32;
  localparam logic [INST_W-1:0] NOP_INST = '0;
  localparam int          WAIT_CTR_W     = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } respState_e;

  // Counter reload value: the capture happens on the cycle the counter reads zero.
  function automatic logic [WAIT_CTR_W-1:0] waitLoadValue(input int waitCycles);
    return WAIT_CTR_W'(waitCycles - 1);
  endfunction

endpackage

// File: rtl/inst_sram_responder_sram_wait_ctr.sv
// Loadable down-counter for SRAM wait states; saturates at zero rather than wrapping.
module sram_wait_ctr
  import inst_sram_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_en,
  input  logic [WAIT_CTR_W-1:0] i_loadVal,
  output logic                  o_zero
);

  logic [WAIT_CTR_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction-fetch responder: turns pc/ce requests into wait-stated asynchronous SRAM reads.
// Optional address window/alignment check enabled by defining INST_SRAM_ADDR_CHECK_EN.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = INST_BASE_ADDR,
  parameter int          ADDR_W      = 20,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              stallreq,
  output logic              addr_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  input  logic [INST_W-1:0] sram_rdata
);

  respState_e        r_state;
  logic [31:0]       r_lastPc;
  logic [31:0]       r_reqPc;
  logic              r_lastValid;
  logic [INST_W-1:0] r_inst;
  logic              r_instValid;
  logic [ADDR_W-1:0] r_sramAddr;
  logic              r_sramCeN;
  logic              r_sramOeN;

  logic              w_newReq;
  logic              w_addrOk;
  logic              w_accept;
  logic              w_ctrZero;
  logic [32:0]       w_offset;

  // Extra top bit catches a borrow when pc lies below the window base.
  assign w_offset = {1'b0, pc} - {1'b0, BASE_ADDR};
  assign w_newReq = ce && (!r_lastValid || (pc != r_lastPc));

`ifdef INST_SRAM_ADDR_CHECK_EN
  localparam logic [32:0] WINDOW_BYTES = 33'(1) << (ADDR_W + 2);
  logic r_addrErr;
  assign w_addrOk = (pc[1:0] == 2'b00) && !w_offset[32] && (w_offset < WINDOW_BYTES);
  assign addr_err = r_addrErr;
`else
  logic w_unusedBits;
  assign w_addrOk     = 1'b1;
  assign addr_err     = 1'b0;
  assign w_unusedBits = ^{w_offset[32:ADDR_W+2], w_offset[1:0]};
`endif

  assign w_accept = (r_state == IDLE) && w_newReq && w_addrOk;
  assign stallreq = w_accept || (r_state == ACCESS);

  sram_wait_ctr u_waitCtr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_en      (r_state == ACCESS),
    .i_loadVal (waitLoadValue(WAIT_CYCLES)),
    .o_zero    (w_ctrZero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastPc    <= '0;
      r_reqPc     <= '0;
      r_lastValid <= 1'b0;
      r_inst      <= '0;
      r_instValid <= 1'b0;
      r_sramAddr  <= '0;
      r_sramCeN   <= 1'b1;
      r_sramOeN   <= 1'b1;
`ifdef INST_SRAM_ADDR_CHECK_EN
      r_addrErr   <= 1'b0;
`endif
    end else begin
      r_instValid <= 1'b0;
`ifdef INST_SRAM_ADDR_CHECK_EN
      r_addrErr   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sramAddr <= w_offset[ADDR_W+1:2];
            r_sramCeN  <= 1'b0;
            r_sramOeN  <= 1'b0;
            r_reqPc    <= pc;
            r_state    <= ACCESS;
          end
`ifdef INST_SRAM_ADDR_CHECK_EN
          // A rejected fetch still completes from the pipeline's view, delivering a NOP.
          else if (w_newReq) begin
            r_inst      <= NOP_INST;
            r_instValid <= 1'b1;
            r_addrErr   <= 1'b1;
            r_lastPc    <= pc;
            r_lastValid <= 1'b1;
          end
`endif
        end
        ACCESS: begin
          if (w_ctrZero) begin
            r_inst      <= sram_rdata;
            r_instValid <= 1'b1;
            r_lastPc    <= r_reqPc;
            r_lastValid <= 1'b1;
            r_sramCeN   <= 1'b1;
            r_sramOeN   <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inst       = r_inst;
  assign inst_valid = r_instValid;
  assign sram_addr  = r_sramAddr;
  assign sram_ce_n  = r_sramCeN;
  assign sram_oe_n  = r_sramOeN;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder: scoreboarded fetches, reset abort, idle and address-check cases.
module tb_inst_sram_responder;
  import inst_sram_responder_pkg::*;

  localparam int          ADDR_W      = 20;
  localparam int          WAIT_CYCLES = 2;
  localparam logic [31:0] BASE        = 32'hBFB00000;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    bit                isErr;
  } expItem_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic [31:0]       pc;
  logic [31:0]       inst;
  logic              instValid;
  logic              stallreq;
  logic              addrErr;
  logic [ADDR_W-1:0] sramAddr;
  logic              sramCeN;
  logic              sramOeN;
  logic [31:0]       sramRdata;

  expItem_t sbQ[$];
  int checks     = 0;
  int errors     = 0;
  int selCount   = 0;
  int validCount = 0;
  logic prevCeN  = 1'b1;

  inst_sram_responder #(
    .BASE_ADDR   (BASE),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (instValid),
    .stallreq   (stallreq),
    .addr_err   (addrErr),
    .sram_addr  (sramAddr),
    .sram_ce_n  (sramCeN),
    .sram_oe_n  (sramOeN),
    .sram_rdata (sramRdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [ADDR_W-1:0] a);
    return (a == '0) ? 32'h3C011234 : {12'hA5A, a};
  endfunction

  function automatic logic [ADDR_W-1:0] wordOf(input logic [31:0] p);
    logic [31:0] off;
    off = p - BASE;
    return off[ADDR_W+1:2];
  endfunction

  // The SRAM only drives meaningful data while both enables are low.
  assign sramRdata = (!sramCeN && !sramOeN) ? memWord(sramAddr) : 32'hDEADBEEF;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ceV, input logic [31:0] pcV);
    ce = ceV;
    pc = pcV;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] pcV, input bit isErr);
    expItem_t it;
    it.addr  = isErr ? '0 : wordOf(pcV);
    it.data  = isErr ? 32'h0 : memWord(wordOf(pcV));
    it.isErr = isErr;
    sbQ.push_back(it);
  endtask

  task automatic waitValid(input string tag);
    int v0;
    int n;
    v0 = validCount;
    n  = 0;
    while ((validCount == v0) && (n < 12)) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(validCount), 32'(v0 + 1));
  endtask

  // Scoreboard side: every inst_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    expItem_t it;
    if ((prevCeN === 1'b1) && (sramCeN === 1'b0)) selCount++;
    prevCeN = sramCeN;
    if (instValid === 1'b1) begin
      validCount++;
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected_inst_valid observed=%h expected=none", inst);
      end else begin
        it = sbQ.pop_front();
        checkOutput("sb_inst", inst, it.data);
        checkOutput("sb_addr_err", {31'b0, addrErr}, {31'b0, it.isErr});
        if (!it.isErr) checkOutput("sb_sram_addr", 32'(sramAddr), 32'(it.addr));
      end
    end
  end

  initial begin
    int expSel;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0);
    repeat (3) step();
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_inst_valid", 32'(instValid), 32'h0);
    checkOutput("rst_addr_err", 32'(addrErr), 32'h0);
    checkOutput("rst_sram_ce_n", 32'(sramCeN), 32'h1);
    checkOutput("rst_sram_oe_n", 32'(sramOeN), 32'h1);
    checkOutput("rst_sram_addr", 32'(sramAddr), 32'h0);
    checkOutput("rst_stallreq", 32'(stallreq), 32'h0);
    rst = 1'b0;

    // First fetch at the reset vector, cycle by cycle.
    applyStimulus(1'b1, BASE);
    pushExp(BASE, 1'b0);
    #1 checkOutput("f0_stall_c0", 32'(stallreq), 32'h1);
    step();
    checkOutput("f0_ce_n", 32'(sramCeN), 32'h0);
    checkOutput("f0_oe_n", 32'(sramOeN), 32'h0);
    checkOutput("f0_addr", 32'(sramAddr), 32'h0);
    checkOutput("f0_stall_c1", 32'(stallreq), 32'h1);
    checkOutput("f0_valid_c1", 32'(instValid), 32'h0);
    step();
    checkOutput("f0_stall_c2", 32'(stallreq), 32'h1);
    checkOutput("f0_valid_c2", 32'(instValid), 32'h0);
    step();
    checkOutput("f0_valid_c3", 32'(instValid), 32'h1);
    checkOutput("f0_inst", inst, 32'h3C011234);
    checkOutput("f0_stall_c3", 32'(stallreq), 32'h0);
    checkOutput("f0_ce_n_off", 32'(sramCeN), 32'h1);
    checkOutput("f0_oe_n_off", 32'(sramOeN), 32'h1);

    // Same pc held: no new access.
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("hold_stall", 32'(stallreq), 32'h0);
      checkOutput("hold_ce_n", 32'(sramCeN), 32'h1);
      checkOutput("hold_inst", inst, 32'h3C011234);
    end
    checkOutput("hold_sel_count", 32'(selCount), 32'd1);

    // Sequential fetches, pc advancing only once stallreq drops.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, BASE + 32'(4 * k));
      pushExp(BASE + 32'(4 * k), 1'b0);
      #1 checkOutput("seq_stall_start", 32'(stallreq), 32'h1);
      waitValid("seq_fetch_done");
      checkOutput("seq_stall_end", 32'(stallreq), 32'h0);
    end
    checkOutput("seq_sel_count", 32'(selCount), 32'd4);

    // Reset during the second ACCESS cycle aborts the read.
    applyStimulus(1'b1, BASE + 32'h10);
    pushExp(BASE + 32'h10, 1'b0);
    step();
    checkOutput("abort_ce_n_active", 32'(sramCeN), 32'h0);
    step();
    rst = 1'b1;
    void'(sbQ.pop_back());
    step();
    checkOutput("abort_ce_n", 32'(sramCeN), 32'h1);
    checkOutput("abort_oe_n", 32'(sramOeN), 32'h1);
    checkOutput("abort_inst", inst, 32'h0);
    checkOutput("abort_valid", 32'(instValid), 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, BASE + 32'h10);
    #1 checkOutput("abort_stall_idle", 32'(stallreq), 32'h0);

    // ce low with a wandering pc: nothing happens.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, $urandom);
      #1 checkOutput("noce_stall", 32'(stallreq), 32'h0);
      step();
      checkOutput("noce_ce_n", 32'(sramCeN), 32'h1);
      checkOutput("noce_inst", inst, 32'h0);
    end
    checkOutput("noce_sel_count", 32'(selCount), 32'd5);

`ifdef INST_SRAM_ADDR_CHECK_EN
    expSel = 5;
    applyStimulus(1'b1, 32'hBFB00002);
    pushExp(32'hBFB00002, 1'b1);
    #1 checkOutput("misalign_stall", 32'(stallreq), 32'h0);
    waitValid("misalign_done");
    step();
    checkOutput("misalign_err_pulse_end", 32'(addrErr), 32'h0);
    applyStimulus(1'b1, 32'h00000000);
    pushExp(32'h00000000, 1'b1);
    #1 checkOutput("below_stall", 32'(stallreq), 32'h0);
    waitValid("below_done");
    checkOutput("below_inst", inst, 32'h0);
`else
    expSel = 7;
    applyStimulus(1'b1, 32'hBFB00002);
    pushExp(32'hBFB00002, 1'b0);
    #1 checkOutput("misalign_stall", 32'(stallreq), 32'h1);
    waitValid("misalign_done");
    step();
    checkOutput("misalign_err_low", 32'(addrErr), 32'h0);
    applyStimulus(1'b1, 32'h00000000);
    pushExp(32'h00000000, 1'b0);
    #1 checkOutput("below_stall", 32'(stallreq), 32'h1);
    waitValid("below_done");
    checkOutput("below_addr", 32'(sramAddr), 32'h00040000);
`endif
    step();
    checkOutput("final_sel_count", 32'(selCount), 32'(expSel));
    checkOutput("final_sb_empty", 32'(sbQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
